// File: rtl/iterative_rotator.sv
// Multi-cycle rotator: rotates an N-bit word by 0..N-1 using a 0-3 position step per clock.
// Optional macro ITERATIVE_ROTATOR_BACK_TO_BACK_EN lets a new request be accepted during the output handshake.
module iterative_rotator #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          inValid,
  output logic          inReady,
  input  logic [N-1:0]  inData,
  input  logic [AW-1:0] inAmount,
  input  logic          inDir,
  output logic          outValid,
  input  logic          outReady,
  output logic [N-1:0]  outData,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t        state, state_next;
  logic [N-1:0]  data, data_next;
  logic [AW-1:0] remaining, remaining_next;
  logic          dir, dir_next;
  logic          out_valid_q, busy_q;
  logic          accept;
  logic [1:0]    step;

  // Rotate by 0..3; indices wrap naturally because N is a power of two.
  function automatic logic [N-1:0] rot_step(input logic [N-1:0] x,
                                            input logic [1:0]   k,
                                            input logic         left);
    logic [N-1:0]  r;
    logic [AW-1:0] src;
    r = '0;
    for (int i = 0; i < N; i++) begin
      src  = left ? (AW'(i) - AW'(k)) : (AW'(i) + AW'(k));
      r[i] = x[src];
    end
    return r;
  endfunction

  assign step = (remaining >= AW'(3)) ? 2'd3 : remaining[1:0];

`ifdef ITERATIVE_ROTATOR_BACK_TO_BACK_EN
  assign inReady = nReset && ((state == IDLE) || ((state == DONE) && outReady));
`else
  assign inReady = nReset && (state == IDLE);
`endif

  assign accept   = inValid && inReady;
  assign outValid = out_valid_q;
  assign outData  = data;
  assign busy     = busy_q;

  always_comb begin
    state_next     = state;
    data_next      = data;
    remaining_next = remaining;
    dir_next       = dir;
    case (state)
      ROTATE: begin
        data_next      = rot_step(data, step, dir);
        remaining_next = remaining - AW'(step);
        if (remaining_next == '0) state_next = DONE;
      end
      DONE: begin
        if (outReady) state_next = IDLE;
      end
      default: ;
    endcase
    // A load can only occur in IDLE, or in DONE when back-to-back mode is on.
    if (accept) begin
      data_next      = inData;
      remaining_next = inAmount;
      dir_next       = inDir;
      state_next     = (inAmount == '0) ? DONE : ROTATE;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state       <= IDLE;
      data        <= '0;
      remaining   <= '0;
      dir         <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_next;
      data        <= data_next;
      remaining   <= remaining_next;
      dir         <= dir_next;
      out_valid_q <= (state_next == DONE);
      busy_q      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_iterative_rotator.sv
// Directed bench for iterative_rotator (N=8): vector table plus hold, reset-abort and streaming sequences.
module tb_iterative_rotator;

  logic       clk = 1'b0;
  logic       nReset;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic [2:0] inAmount;
  logic       inDir;
  logic       outValid;
  logic       outReady;
  logic [7:0] outData;
  logic       busy;

  int vec_count = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] amount;
    logic       dir;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  iterative_rotator #(.N(8)) dut (
    .clk(clk), .nReset(nReset),
    .inValid(inValid), .inReady(inReady), .inData(inData),
    .inAmount(inAmount), .inDir(inDir),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits for inReady, issues one request, then counts accept-edge-relative cycles to outValid.
  task automatic applyStimulus(input logic [7:0] d, input logic [2:0] a, input logic dr,
                               output int lat, output logic [7:0] res, output logic seen);
    int w;
    w = 0;
    @(negedge clk);
    while (!inReady && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!inReady) checkOutput("inReady_timeout", 32'(inReady), 32'd1);
    inData = d; inAmount = a; inDir = dr; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res  = outData;
    seen = outValid;
  endtask

  initial begin
    int         lat;
    logic [7:0] res;
    logic       seen;
    logic       leaked;
    logic       acc;
    int         sent, nres;
    int         res_t[2];
    logic [7:0] res_d[2];

    vecs[0] = '{8'hB4, 3'd5, 1'b0, 8'hA5, 3};
    vecs[1] = '{8'h81, 3'd7, 1'b1, 8'hC0, 4};
    vecs[2] = '{8'h5A, 3'd0, 1'b0, 8'h5A, 1};
    vecs[3] = '{8'h01, 3'd1, 1'b0, 8'h80, 2};
    vecs[4] = '{8'h80, 3'd1, 1'b1, 8'h01, 2};
    vecs[5] = '{8'h96, 3'd4, 1'b1, 8'h69, 3};
    vecs[6] = '{8'hC3, 3'd6, 1'b0, 8'h0F, 3};
    vecs[7] = '{8'h12, 3'd3, 1'b1, 8'h90, 2};

    nReset = 1'b0; inValid = 1'b0; inData = '0; inAmount = '0; inDir = 1'b0; outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_outData", 32'(outData), 32'h00);
    checkOutput("rst_outValid", 32'(outValid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_inReady", 32'(inReady), 32'd0);
    nReset = 1'b1;
    #1;
    checkOutput("idle_inReady", 32'(inReady), 32'd1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].data, vecs[i].amount, vecs[i].dir, lat, res, seen);
      checkOutput($sformatf("vec%0d_valid", i), 32'(seen), 32'd1);
      checkOutput($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      @(posedge clk); #1;
    end

    // Backpressure: result must hold while outReady stays low.
    outReady = 1'b0;
    applyStimulus(8'h01, 3'd3, 1'b1, lat, res, seen);
    checkOutput("hold_valid", 32'(seen), 32'd1);
    checkOutput("hold_data", 32'(res), 32'h08);
    checkOutput("hold_latency", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d_outValid", c), 32'(outValid), 32'd1);
      checkOutput($sformatf("hold%0d_outData", c), 32'(outData), 32'h08);
      checkOutput($sformatf("hold%0d_inReady", c), 32'(inReady), 32'd0);
      checkOutput($sformatf("hold%0d_busy", c), 32'(busy), 32'd1);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_outValid", 32'(outValid), 32'd0);
    checkOutput("release_busy", 32'(busy), 32'd0);
    checkOutput("release_inReady", 32'(inReady), 32'd1);

    // Reset in the second ROTATE cycle discards the in-flight word.
    @(negedge clk);
    inData = 8'hFF; inAmount = 3'd6; inDir = 1'b0; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    checkOutput("abort_busy_rot1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    checkOutput("abort_busy_rot2", 32'(busy), 32'd1);
    nReset = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_outData", 32'(outData), 32'h00);
    checkOutput("abort_outValid", 32'(outValid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_inReady", 32'(inReady), 32'd0);
    nReset = 1'b1;
    leaked = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (outValid) leaked = 1'b1;
    end
    checkOutput("abort_no_result", 32'(leaked), 32'd0);

    // Two-request stream; the gap between results depends on back-to-back mode.
    @(negedge clk);
    inData = 8'h01; inAmount = 3'd1; inDir = 1'b0; inValid = 1'b1;
    sent = 0; nres = 0;
    res_t[0] = 0; res_t[1] = 0; res_d[0] = '0; res_d[1] = '0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      acc = inValid && inReady;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent == 1) begin
          inData = 8'h80; inAmount = 3'd1; inDir = 1'b1;
        end else begin
          inValid = 1'b0;
        end
      end
      if (outValid && nres < 2) begin
        res_t[nres] = c;
        res_d[nres] = outData;
        nres++;
      end
    end
    inValid = 1'b0;
    checkOutput("stream_results", 32'(nres), 32'd2);
    checkOutput("stream_first", 32'(res_d[0]), 32'h80);
    checkOutput("stream_second", 32'(res_d[1]), 32'h01);
`ifdef ITERATIVE_ROTATOR_BACK_TO_BACK_EN
    checkOutput("stream_gap", 32'(res_t[1] - res_t[0]), 32'd2);
`else
    checkOutput("stream_gap", 32'(res_t[1] - res_t[0]), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
